// File: rtl/debounce_bank.sv
// Multi-channel pushbutton conditioner: sync, debounce, press/release pulses
// and optional hold-to-repeat pulses, one independent lane per channel.
module debounce_bank #(
  parameter int unsigned          CHANNELS      = 4,
  parameter int unsigned          DB_CYCLES     = 131072,
  parameter int unsigned          HOLD_CYCLES   = 50000000,
  parameter int unsigned          REPEAT_CYCLES = 10000000,
  parameter logic [CHANNELS-1:0]  INVERT        = '0,
  parameter logic [CHANNELS-1:0]  REPEAT_EN     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_btn,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_repeat
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES);
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RPT  = 2'd2
  } rpt_state_e;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic            sync1_q;
    logic            sync2_q;
    logic            lvl;
    logic            state_q;
    logic            state_d;
    logic            press_q;
    logic            release_q;
    logic            db_tgl;
    logic [DB_W-1:0] db_q;
    logic [DB_W-1:0] db_d;

    // Sync flops rest at the inactive pin level so reset yields logical 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= INVERT[i];
        sync2_q <= INVERT[i];
      end else begin
        sync1_q <= i_btn[i];
        sync2_q <= sync1_q;
      end
    end

    assign lvl = sync2_q ^ INVERT[i];

    always_comb begin
      db_d    = db_q;
      state_d = state_q;
      db_tgl  = 1'b0;
      if (lvl == state_q) begin
        db_d = '0;
      end else if (db_q == DB_W'(DB_CYCLES - 1)) begin
        db_d    = '0;
        state_d = ~state_q;
        db_tgl  = 1'b1;
      end else begin
        db_d = db_q + DB_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q      <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_q      <= db_d;
        state_q   <= state_d;
        press_q   <= db_tgl & ~state_q;
        release_q <= db_tgl & state_q;
      end
    end

    assign o_state[i]   = state_q;
    assign o_press[i]   = press_q;
    assign o_release[i] = release_q;

    if (REPEAT_EN[i]) begin : g_rpt
      rpt_state_e       fsm_q;
      rpt_state_e       fsm_d;
      logic [RPT_W-1:0] rc_q;
      logic [RPT_W-1:0] rc_d;
      logic             rpt_d;
      logic             rpt_q;

      // Expiry is detected one count early so the registered pulse lands on the target cycle.
      always_comb begin
        fsm_d = fsm_q;
        rc_d  = rc_q;
        rpt_d = 1'b0;
        unique case (fsm_q)
          S_IDLE: begin
            if (db_tgl && !state_q) begin
              fsm_d = S_HOLD;
              rc_d  = '0;
            end
          end
          S_HOLD: begin
            if (rc_q == RPT_W'(HOLD_CYCLES - 1)) begin
              rpt_d = 1'b1;
              rc_d  = '0;
              fsm_d = S_RPT;
            end else begin
              rc_d = rc_q + RPT_W'(1);
            end
          end
          S_RPT: begin
            if (rc_q == RPT_W'(REPEAT_CYCLES - 1)) begin
              rpt_d = 1'b1;
              rc_d  = '0;
            end else begin
              rc_d = rc_q + RPT_W'(1);
            end
          end
          default: begin
            fsm_d = S_IDLE;
            rc_d  = '0;
          end
        endcase
        // Release wins over a coinciding repeat expiry.
        if (db_tgl && state_q) begin
          fsm_d = S_IDLE;
          rc_d  = '0;
          rpt_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fsm_q <= S_IDLE;
          rc_q  <= '0;
          rpt_q <= 1'b0;
        end else begin
          fsm_q <= fsm_d;
          rc_q  <= rc_d;
          rpt_q <= rpt_d;
        end
      end

      assign o_repeat[i] = rpt_q;
    end else begin : g_no_rpt
      assign o_repeat[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised + directed bench for debounce_bank; a cycle-level reference model
// feeds an expectation queue that a negedge monitor drains and compares.
module tb_debounce_bank;

  localparam int unsigned CH   = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 3;
  localparam logic [1:0]  INV  = 2'b10;
  localparam logic [1:0]  REN  = 2'b01;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] rp;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_btn;
  logic [1:0] o_state;
  logic [1:0] o_press;
  logic [1:0] o_release;
  logic [1:0] o_repeat;

  debounce_bank #(
    .CHANNELS      (CH),
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .INVERT        (INV),
    .REPEAT_EN     (REN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (i_btn),
    .o_state   (o_state),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  exp_t exp_q[$];

  // Reference model state: pin samples, accepted level, mismatch-run start, press time.
  logic [1:0] pins[$];
  logic [1:0] m_state;
  logic [1:0] m_lvl;
  int         mis_start[2];
  int         press_at[2];
  int         edge_n;
  int         age;
  exp_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    m_e = '0;
    if (!rst_n) begin
      m_state = '0;
      pins.delete();
      pins.push_back(INV);
      pins.push_back(INV);
      for (int c = 0; c < 2; c++) begin
        mis_start[c] = -1;
        press_at[c]  = 0;
      end
      edge_n = 0;
      exp_q.delete();
      exp_q.push_back(m_e);
      started = 1'b1;
    end else begin
      edge_n++;
      // The level seen at this edge is the pin sampled two edges earlier.
      m_lvl = pins[0] ^ INV;
      pins.push_back(i_btn);
      void'(pins.pop_front());
      for (int c = 0; c < 2; c++) begin
        if (m_lvl[c] == m_state[c]) begin
          mis_start[c] = -1;
        end else begin
          if (mis_start[c] < 0) mis_start[c] = edge_n;
          if (edge_n - mis_start[c] + 1 >= int'(DB)) begin
            m_state[c]   = ~m_state[c];
            mis_start[c] = -1;
            if (m_state[c]) begin
              m_e.pr[c]   = 1'b1;
              press_at[c] = edge_n;
            end else begin
              m_e.rl[c] = 1'b1;
            end
          end
        end
        if (REN[c] && m_state[c] && !m_e.pr[c]) begin
          age = edge_n - press_at[c];
          if (age >= int'(HOLD) && ((age - int'(HOLD)) % int'(REP)) == 0)
            m_e.rp[c] = 1'b1;
        end
      end
      m_e.st = m_state;
      exp_q.push_back(m_e);
    end
  end

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty t=%0t got=none expected=entry", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("o_state",   o_state,   mon_e.st);
        chk("o_press",   o_press,   mon_e.pr);
        chk("o_release", o_release, mon_e.rl);
        chk("o_repeat",  o_repeat,  mon_e.rp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    i_btn = 2'b10;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_cyc(50);
    // Clean press on ch0, held long enough to see repeats.
    i_btn = 2'b11; wait_cyc(20);
    i_btn = 2'b10; wait_cyc(12);
    // Glitch shorter than the debounce window, then one exactly as long.
    i_btn = 2'b11; wait_cyc(3);
    i_btn = 2'b10; wait_cyc(10);
    i_btn = 2'b11; wait_cyc(4);
    i_btn = 2'b10; wait_cyc(15);
    // Long hold with several repeats, then release.
    i_btn = 2'b11; wait_cyc(30);
    i_btn = 2'b10; wait_cyc(20);
    // Simultaneous press on both channels (ch1 active-low).
    i_btn = 2'b01; wait_cyc(15);
    i_btn = 2'b10; wait_cyc(15);
    // Reset while ch1 held and ch0 mid-debounce, then release with both held.
    i_btn = 2'b00; wait_cyc(12);
    i_btn = 2'b01; wait_cyc(4);
    rst_n = 1'b0;  wait_cyc(2);
    rst_n = 1'b1;  wait_cyc(15);
    i_btn = 2'b10; wait_cyc(10);
    // Random pin activity with a mix of glitches and long holds.
    for (int k = 0; k < 80; k++) begin
      i_btn = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) wait_cyc(int'($urandom_range(12, 30)));
      else                           wait_cyc(int'($urandom_range(1, 8)));
    end
    i_btn = 2'b10;
    wait_cyc(20);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
